// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Brief    : Multi-cycle radix-2 restoring divider (signed/unsigned q and r).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              div_enable,
    input  logic              div_sign,
    input  logic [DATA_W-1:0] div_src1,
    input  logic [DATA_W-1:0] div_src2,
    input  logic              div_ack,
    output logic              div_complete,
    output logic [DATA_W-1:0] div_quotient,
    output logic [DATA_W-1:0] div_remainder,
    output logic              div_busy
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_CALC  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   dvd_q;
    logic [DATA_W-1:0]   dvs_q;
    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   src1_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                signed_q;
    logic                sign1_q;
    logic                sign2_q;
    logic                zero_q;
    logic [DATA_W-1:0]   quo_out_q;
    logic [DATA_W-1:0]   rem_out_q;
    logic                complete_q;
    logic                busy_q;

    logic [DATA_W:0]     w_shift;
    logic                w_ge;
    logic [DATA_W-1:0]   rem_d;
    logic [DATA_W-1:0]   dvd_d;
    logic [DATA_W-1:0]   w_quo_fix;
    logic [DATA_W-1:0]   w_rem_fix;

    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                  input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // The dividend register doubles as the quotient accumulator: each step
    // shifts one dividend bit out of the top and one quotient bit into the bottom.
    always_comb begin
        w_shift = {rem_q, dvd_q[DATA_W-1]};
        w_ge    = (w_shift >= {1'b0, dvs_q});
        rem_d   = w_ge ? (w_shift[DATA_W-1:0] - dvs_q) : w_shift[DATA_W-1:0];
        dvd_d   = {dvd_q[DATA_W-2:0], w_ge};
        if (zero_q) begin
            w_quo_fix = '1;
            w_rem_fix = src1_q;
        end else begin
            w_quo_fix = abs_val(dvd_d, signed_q & (sign1_q ^ sign2_q));
            w_rem_fix = abs_val(rem_d, signed_q & sign1_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            src1_q     <= '0;
            cnt_q      <= '0;
            signed_q   <= 1'b0;
            sign1_q    <= 1'b0;
            sign2_q    <= 1'b0;
            zero_q     <= 1'b0;
            quo_out_q  <= '0;
            rem_out_q  <= '0;
            complete_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    complete_q <= 1'b0;
                    busy_q     <= 1'b0;
                    if (div_enable) begin
                        dvd_q    <= div_src1;
                        dvs_q    <= div_src2;
                        src1_q   <= div_src1;
                        signed_q <= div_sign;
                        sign1_q  <= div_sign & div_src1[DATA_W-1];
                        sign2_q  <= div_sign & div_src2[DATA_W-1];
                        zero_q   <= (div_src2 == '0);
                        busy_q   <= 1'b1;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (!div_enable) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        dvd_q   <= abs_val(dvd_q, sign1_q);
                        dvs_q   <= abs_val(dvs_q, sign2_q);
                        rem_q   <= '0;
                        cnt_q   <= CNT_W'(DATA_W);
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (!div_enable) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= dvd_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            quo_out_q  <= w_quo_fix;
                            rem_out_q  <= w_rem_fix;
                            complete_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (div_ack || !div_enable) begin
                        complete_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign div_complete  = complete_q;
    assign div_quotient  = quo_out_q;
    assign div_remainder = rem_out_q;
    assign div_busy      = busy_q;

endmodule

`default_nettype wire
